ex_mem_reg: RTL
===============

# ex_mem_reg

EX/MEM pipeline register of the five-stage RISC-V core, between the execute stage and the MEM stage (data memory plus branch AND). Captures the ALU result, store data, branch target, zero flag, destination register and the M/WB control bits each cycle. Supports downstream stall (hold), branch-taken flush (bubble insertion) and a valid bit. Exposes a forwarding port and a saturating squash counter for debug.

## Interface
- `DATA_WIDTH`, 32: width of the address, store-data and branch-target datapaths
- `RD_WIDTH`, 5: width of the destination register index
- `CNT_WIDTH`, 16: width of the squash counter
- `clk` in 1: single clock; all state updates on the rising edge
- `reset` in 1: synchronous, active-high
- `STALL` in 1: hold the current contents; no load from EX
- `FLUSH` in 1: load a bubble instead of the EX instruction (driven from MEM-stage `PCSrc`)
- `VALID_EX` in 1: the EX slot holds a real instruction
- `ALU_RESULT_EX` in DATA_WIDTH: ALU result, used as the memory address
- `REG_DATA2_EX` in DATA_WIDTH: store data
- `ZERO_EX` in 1: ALU zero flag
- `BRANCH_SUM_EX` in DATA_WIDTH: branch target
- `RD_EX` in RD_WIDTH: destination register
- `MEM_READ_EX`, `MEM_WRITE_EX`, `BRANCH_EX`, `REG_WRITE_EX`, `MEM_TO_REG_EX` in 1 each: control bits
- `ADDRESS_MEM`, `WRITE_DATA`, `BRANCH_SUM` out DATA_WIDTH: registered datapath to the MEM stage
- `ZERO`, `MEM_READ`, `MEM_WRITE`, `BRANCH` out 1: registered to the MEM stage
- `RD_MEM` out RD_WIDTH, `REG_WRITE_MEM` out 1, `MEM_TO_REG_MEM` out 1: passed on to MEM/WB
- `VALID_MEM` out 1: the MEM slot holds a real instruction
- `FWD_EN` out 1, `FWD_RD` out RD_WIDTH, `FWD_DATA` out DATA_WIDTH: EX/MEM forwarding source
- `SQUASH_CNT` out CNT_WIDTH: number of valid EX instructions squashed by FLUSH

## Operation
- Update priority on each rising edge: `reset` > `FLUSH` > `STALL` > normal load.
- **Normal load** (no reset, flush or stall): every registered field takes its `*_EX` input. `VALID_MEM` <= `VALID_EX`.
- **Stall:** all fields and `VALID_MEM` hold their values. `SQUASH_CNT` holds.
- **Flush:** load a bubble.
  - `VALID_MEM`, `MEM_READ`, `MEM_WRITE`, `BRANCH`, `REG_WRITE_MEM`, `MEM_TO_REG_MEM` <= 0.
  - Datapath fields and `RD_MEM` <= 0.
  - This applies even when `STALL` is high at the same time (flush wins).
- **Invalid input:** when loading with `VALID_EX`=0, the control bits are still gated to 0 as above. The datapath fields load normally.
- **Squash counter:**
  - Increments by 1 on a flush edge when `VALID_EX`=1 and `STALL`=0.
  - Saturates at all-ones; no wrap-around.
  - Unchanged in every other case.
- **Forwarding port** (combinational from registered state only, no EX inputs):
  - `FWD_EN` = `VALID_MEM` & `REG_WRITE_MEM` & (`RD_MEM` != 0).
  - `FWD_RD` = `RD_MEM`.
  - `FWD_DATA` = `ADDRESS_MEM`.
  - A load in MEM (`MEM_TO_REG_MEM`=1) still raises `FWD_EN`. The hazard unit suppresses it; this block does not.
- **Reset:** all outputs and `SQUASH_CNT` are 0 the cycle after the reset edge.

## Timing
- Latency: an EX input is visible on the outputs 1 cycle after the edge that loads it.
- Only the `FWD_*` outputs are combinational, and they are pure functions of registered state.
- Stall length is unbounded. Contents stay bit-identical for N stalled cycles, and the load resumes on the first edge with `STALL`=0.
- `FLUSH` is sampled only at the edge; one asserted edge inserts exactly one bubble.
- Reset asserted mid-stall or mid-flush clears the register on that edge. The first load happens on the first edge after `reset` deasserts.

## Test plan
- **Reset:** set all EX inputs to 1s and pulse `reset` for 1 cycle -> every output and `SQUASH_CNT` = 0; `FWD_EN`=0.
- **Load/forward:**
  - Stimulus: `VALID_EX`=1, `ALU_RESULT_EX`=0x00000040, `RD_EX`=5, `REG_WRITE_EX`=1.
  - Response: the next cycle `ADDRESS_MEM`=0x40, `FWD_EN`=1, `FWD_RD`=5, `FWD_DATA`=0x40.
  - With `RD_EX`=0 instead -> `FWD_EN`=0.
- **Stall hold:**
  - Stimulus: load a store (`MEM_WRITE_EX`=1, `REG_DATA2_EX`=0xDEADBEEF), then hold `STALL`=1 for 3 cycles while the EX inputs change.
  - Response: the outputs stay at the store values for all 3 cycles, then take the new EX values 1 cycle after `STALL` drops.
- **Flush:**
  - Stimulus: `VALID_EX`=1, `BRANCH_EX`=1, `MEM_READ_EX`=1, `FLUSH`=1.
  - Response: `VALID_MEM`=0, all control bits 0, `SQUASH_CNT`=1.
  - The same stimulus with `VALID_EX`=0 -> bubble, with `SQUASH_CNT` unchanged.
- **Flush+stall:** `FLUSH`=1 and `STALL`=1 on the same edge -> bubble inserted, `SQUASH_CNT` unchanged.
- **Saturation:** preload the counter by 65535 valid flushes, then apply one more -> `SQUASH_CNT`=0xFFFF and stays there.

Source files
------------

// File: rtl/ex_mem_reg_if.sv
// EX -> MEM pipeline register bus: EX-stage payload and control in, MEM-stage payload and forwarding source out.
interface ex_mem_reg_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RD_WIDTH   = 5,
    parameter int unsigned CNT_WIDTH  = 16
);
    // Pipeline control and EX-stage payload
    logic                  STALL;
    logic                  FLUSH;
    logic                  VALID_EX;
    logic [DATA_WIDTH-1:0] ALU_RESULT_EX;
    logic [DATA_WIDTH-1:0] REG_DATA2_EX;
    logic                  ZERO_EX;
    logic [DATA_WIDTH-1:0] BRANCH_SUM_EX;
    logic [RD_WIDTH-1:0]   RD_EX;
    logic                  MEM_READ_EX;
    logic                  MEM_WRITE_EX;
    logic                  BRANCH_EX;
    logic                  REG_WRITE_EX;
    logic                  MEM_TO_REG_EX;

    // MEM-stage payload, forwarding source and debug counter
    logic [DATA_WIDTH-1:0] ADDRESS_MEM;
    logic [DATA_WIDTH-1:0] WRITE_DATA;
    logic [DATA_WIDTH-1:0] BRANCH_SUM;
    logic                  ZERO;
    logic                  MEM_READ;
    logic                  MEM_WRITE;
    logic                  BRANCH;
    logic [RD_WIDTH-1:0]   RD_MEM;
    logic                  REG_WRITE_MEM;
    logic                  MEM_TO_REG_MEM;
    logic                  VALID_MEM;
    logic                  FWD_EN;
    logic [RD_WIDTH-1:0]   FWD_RD;
    logic [DATA_WIDTH-1:0] FWD_DATA;
    logic [CNT_WIDTH-1:0]  SQUASH_CNT;

    modport master (
        output STALL, FLUSH, VALID_EX, ALU_RESULT_EX, REG_DATA2_EX, ZERO_EX,
               BRANCH_SUM_EX, RD_EX, MEM_READ_EX, MEM_WRITE_EX, BRANCH_EX,
               REG_WRITE_EX, MEM_TO_REG_EX,
        input  ADDRESS_MEM, WRITE_DATA, BRANCH_SUM, ZERO, MEM_READ, MEM_WRITE,
               BRANCH, RD_MEM, REG_WRITE_MEM, MEM_TO_REG_MEM, VALID_MEM,
               FWD_EN, FWD_RD, FWD_DATA, SQUASH_CNT
    );

    modport slave (
        input  STALL, FLUSH, VALID_EX, ALU_RESULT_EX, REG_DATA2_EX, ZERO_EX,
               BRANCH_SUM_EX, RD_EX, MEM_READ_EX, MEM_WRITE_EX, BRANCH_EX,
               REG_WRITE_EX, MEM_TO_REG_EX,
        output ADDRESS_MEM, WRITE_DATA, BRANCH_SUM, ZERO, MEM_READ, MEM_WRITE,
               BRANCH, RD_MEM, REG_WRITE_MEM, MEM_TO_REG_MEM, VALID_MEM,
               FWD_EN, FWD_RD, FWD_DATA, SQUASH_CNT
    );
endinterface

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with stall hold, flush bubble insertion, forwarding source
// and a saturating count of squashed valid instructions.
module ex_mem_reg #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RD_WIDTH   = 5,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input logic         clk,
    input logic         reset,
    ex_mem_reg_if.slave bus
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [DATA_WIDTH-1:0] address_mem;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] branch_sum;
    logic                  zero;
    logic                  mem_read;
    logic                  mem_write;
    logic                  branch;
    logic [RD_WIDTH-1:0]   rd_mem;
    logic                  reg_write_mem;
    logic                  mem_to_reg_mem;
    logic                  valid_mem;
    logic [CNT_WIDTH-1:0]  squash_cnt;

    // Priority: reset > flush > stall > load; control bits are gated by the EX valid bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            address_mem    <= '0;
            write_data     <= '0;
            branch_sum     <= '0;
            zero           <= 1'b0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            branch         <= 1'b0;
            rd_mem         <= '0;
            reg_write_mem  <= 1'b0;
            mem_to_reg_mem <= 1'b0;
            valid_mem      <= 1'b0;
            squash_cnt     <= '0;
        end else if (bus.FLUSH) begin
            address_mem    <= '0;
            write_data     <= '0;
            branch_sum     <= '0;
            zero           <= 1'b0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            branch         <= 1'b0;
            rd_mem         <= '0;
            reg_write_mem  <= 1'b0;
            mem_to_reg_mem <= 1'b0;
            valid_mem      <= 1'b0;
            // A stalled flush squashes nothing new: the EX instruction is replayed later.
            if (bus.VALID_EX && !bus.STALL && (squash_cnt != CNT_MAX)) begin
                squash_cnt <= squash_cnt + CNT_WIDTH'(1);
            end
        end else if (!bus.STALL) begin
            address_mem    <= bus.ALU_RESULT_EX;
            write_data     <= bus.REG_DATA2_EX;
            branch_sum     <= bus.BRANCH_SUM_EX;
            zero           <= bus.ZERO_EX;
            rd_mem         <= bus.RD_EX;
            mem_read       <= bus.VALID_EX & bus.MEM_READ_EX;
            mem_write      <= bus.VALID_EX & bus.MEM_WRITE_EX;
            branch         <= bus.VALID_EX & bus.BRANCH_EX;
            reg_write_mem  <= bus.VALID_EX & bus.REG_WRITE_EX;
            mem_to_reg_mem <= bus.VALID_EX & bus.MEM_TO_REG_EX;
            valid_mem      <= bus.VALID_EX;
        end
    end

    assign bus.ADDRESS_MEM    = address_mem;
    assign bus.WRITE_DATA     = write_data;
    assign bus.BRANCH_SUM     = branch_sum;
    assign bus.ZERO           = zero;
    assign bus.MEM_READ       = mem_read;
    assign bus.MEM_WRITE      = mem_write;
    assign bus.BRANCH         = branch;
    assign bus.RD_MEM         = rd_mem;
    assign bus.REG_WRITE_MEM  = reg_write_mem;
    assign bus.MEM_TO_REG_MEM = mem_to_reg_mem;
    assign bus.VALID_MEM      = valid_mem;
    assign bus.SQUASH_CNT     = squash_cnt;

    // Forwarding source; loads are not filtered here, the hazard unit handles them.
    assign bus.FWD_EN   = valid_mem & reg_write_mem & (rd_mem != '0);
    assign bus.FWD_RD   = rd_mem;
    assign bus.FWD_DATA = address_mem;
endmodule
